msrv_32_machine_control: RTL and testbench
==========================================

Name: msrv_32_machine_control

Overview:
- Trap and return sequencer for the msrv_32 core; the responder to the decoder's exception flags.
- Consumes illegal_instr, misaligned_load and misaligned_store from the decoder, plus the ECALL/EBREAK/MRET encodings and interrupt requests.
- Produces trap_taken, which feeds back to the decoder to suppress mem_wr_req, and drives PC select, pipeline flush and CSR update strobes.
- Moore FSM: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.

Parameters:
- BOOT_SEL, 2'b00, pc_src_out code for the boot address
- EPC_SEL, 2'b01, pc_src_out code for mepc (MRET)
- TVEC_SEL, 2'b10, pc_src_out code for the trap vector
- NEXT_SEL, 2'b11, pc_src_out code for normal next PC

Ports:
- clk_in  in  1  core clock
- rst_n_in  in  1  asynchronous active-low reset
- illegal_instr_in  in  1  from decoder
- misaligned_load_in  in  1  from decoder
- misaligned_store_in  in  1  from decoder
- misaligned_instr_in  in  1  target-PC misalignment from branch unit
- opcode_6_to_2_in  in  5  instruction opcode[6:2]
- funct3_in  in  3  instruction funct3
- funct12_in  in  12  instruction [31:20]
- rs1_addr_in  in  5  instruction rs1 field
- rd_addr_in  in  5  instruction rd field
- e_irq_in  in  1  external interrupt request
- t_irq_in  in  1  timer interrupt request
- s_irq_in  in  1  software interrupt request
- mie_in  in  1  mstatus.MIE
- meie_in  in  1  mie.MEIE
- mtie_in  in  1  mie.MTIE
- msie_in  in  1  mie.MSIE
- trap_taken_out  out  1  high in TRAP_TAKEN; to decoder trap_taken_in
- pc_src_out  out  2  PC mux select
- flush_out  out  1  kill the instruction in the pipeline
- set_epc_out  out  1  CSR file captures PC into mepc
- set_cause_out  out  1  CSR file captures cause_out and i_or_e_out
- mie_clear_out  out  1  MIE to MPIE, MIE cleared
- mie_set_out  out  1  MPIE to MIE
- instret_inc_out  out  1  minstret increment
- cause_out  out  4  registered trap cause code
- i_or_e_out  out  1  registered: 1 = interrupt, 0 = exception

Behaviour:
- Reset: asynchronous, active low. While rst_n_in=0, state=RESET, cause_out=0, i_or_e_out=0.
- RESET outputs: pc_src=BOOT_SEL, flush=1; all strobes and trap_taken=0.
- RESET -> OPERATING on the first clock edge after rst_n_in deasserts.
- Decode: opcode_6_to_2_in=11100, funct3=000, rs1=0 and rd=0 qualify a system instruction.
  - ECALL: funct12=0x000. EBREAK: funct12=0x001. MRET: funct12=0x302.
- exc = misaligned_instr | illegal_instr | ebreak | ecall | misaligned_load | misaligned_store.
- irq = mie_in & ((e_irq & meie) | (s_irq & msie) | (t_irq & mtie)).
- OPERATING outputs: pc_src=NEXT_SEL, flush=0. instret_inc_out=1 unless exc or irq.
- OPERATING transitions, in priority order:
  - exc -> TRAP_TAKEN, exception (i_or_e=0).
  - irq -> TRAP_TAKEN, interrupt (i_or_e=1).
  - MRET -> TRAP_RETURN.
  - otherwise stay in OPERATING.
- Exceptions beat interrupts. A masked or losing interrupt stays pending on its input and is re-evaluated on return.
- Exception cause priority, highest first: misaligned_instr=0, illegal=2, ebreak=3, ecall=11, misaligned_load=4, misaligned_store=6.
- Interrupt cause priority, highest first: external=11, software=3, timer=7.
- cause_out and i_or_e_out load on the edge entering TRAP_TAKEN; hold otherwise.
- TRAP_TAKEN outputs (exactly one cycle): trap_taken=1, pc_src=TVEC_SEL, flush=1, set_epc=1, set_cause=1, mie_clear=1, instret_inc=0.
- TRAP_RETURN outputs (exactly one cycle): pc_src=EPC_SEL, flush=1, mie_set=1, instret_inc=1.
- TRAP_TAKEN and TRAP_RETURN both return unconditionally to OPERATING. Inputs in those states are ignored.
- Reset asserted in any state forces RESET immediately; no strobe may remain high.
- Illegal or unused state encodings recover to RESET.

Test Plan:
- Reset: hold rst_n_in=0 for 3 cycles -> pc_src=00, flush=1, trap_taken=0, cause=0. Release -> next cycle pc_src=11, flush=0.
- illegal_instr_in=1 for one cycle -> next cycle trap_taken=1, cause=2, i_or_e=0, pc_src=10, set_epc=set_cause=mie_clear=1. Cycle after: pc_src=11.
- misaligned_load_in=1 with e_irq=1, mie=1, meie=1 -> trap with cause=4, i_or_e=0. Then drive MRET with e_irq still high -> pc_src=01, mie_set=1. Then set mie=1 -> trap with cause=11, i_or_e=1.
- t_irq=1, mtie=1, mie=0 -> no trap, instret_inc=1. Raise mie=1 -> next cycle trap, cause=7.
- ECALL (funct12=0x000) and EBREAK (funct12=0x001) -> causes 11 and 3. Same encoding with rd=5 -> no trap.
- rst_n_in pulled low during TRAP_TAKEN -> trap_taken, set_epc and set_cause drop immediately; pc_src=00.

Source files
------------

// File: rtl/msrv_32_machine_control.sv
// msrv_32_machine_control
// Trap and return sequencer for the msrv_32 core. Watches the decoder's
// exception flags, the SYSTEM-opcode encodings (ECALL/EBREAK/MRET) and the
// enabled interrupt requests. It then steers the PC mux, flushes the pipeline
// and strobes the CSR file through a four-state Moore machine:
// RESET -> OPERATING <-> {TRAP_TAKEN, TRAP_RETURN}.

module msrv_32_machine_control #(
    parameter logic [1:0] BOOT_SEL = 2'b00,  // pc_src_out: boot address
    parameter logic [1:0] EPC_SEL  = 2'b01,  // pc_src_out: mepc (MRET)
    parameter logic [1:0] TVEC_SEL = 2'b10,  // pc_src_out: trap vector
    parameter logic [1:0] NEXT_SEL = 2'b11   // pc_src_out: sequential next PC
) (
    input  logic        clk_in,
    input  logic        rst_n_in,

    // exception sources
    input  logic        illegal_instr_in,
    input  logic        misaligned_load_in,
    input  logic        misaligned_store_in,
    input  logic        misaligned_instr_in,

    // instruction fields used to recognise ECALL / EBREAK / MRET
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [2:0]  funct3_in,
    input  logic [11:0] funct12_in,
    input  logic [4:0]  rs1_addr_in,
    input  logic [4:0]  rd_addr_in,

    // interrupt requests and their enables
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    input  logic        mie_in,
    input  logic        meie_in,
    input  logic        mtie_in,
    input  logic        msie_in,

    // sequencing outputs
    output logic        trap_taken_out,
    output logic [1:0]  pc_src_out,
    output logic        flush_out,
    output logic        set_epc_out,
    output logic        set_cause_out,
    output logic        mie_clear_out,
    output logic        mie_set_out,
    output logic        instret_inc_out,
    output logic [3:0]  cause_out,
    output logic        i_or_e_out
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] STATE_RESET       = 2'b00;
    localparam logic [1:0] STATE_OPERATING   = 2'b01;
    localparam logic [1:0] STATE_TRAP_TAKEN  = 2'b10;
    localparam logic [1:0] STATE_TRAP_RETURN = 2'b11;

    // ------------------------------------------------------------------
    // Instruction field constants
    // ------------------------------------------------------------------
    localparam logic [4:0]  OPCODE_SYSTEM = 5'b11100;
    localparam logic [2:0]  FUNCT3_PRIV   = 3'b000;
    localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
    localparam logic [11:0] FUNCT12_EBREAK = 12'h001;
    localparam logic [11:0] FUNCT12_MRET   = 12'h302;

    // ------------------------------------------------------------------
    // mcause codes
    // ------------------------------------------------------------------
    localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    localparam logic [3:0] CAUSE_SW_IRQ    = 4'd3;
    localparam logic [3:0] CAUSE_TIMER_IRQ = 4'd7;
    localparam logic [3:0] CAUSE_EXT_IRQ   = 4'd11;

    logic [1:0] state;
    logic [1:0] next_state;

    logic       sys_instr;
    logic       is_ecall;
    logic       is_ebreak;
    logic       is_mret;

    logic       e_irq_pend;
    logic       t_irq_pend;
    logic       s_irq_pend;

    logic       exc;
    logic       irq;
    logic       take_trap;

    logic [3:0] exc_cause;
    logic [3:0] irq_cause;

    // ------------------------------------------------------------------
    // SYSTEM instruction decode. Only the all-zero rs1/rd/funct3 forms are
    // the privileged ECALL/EBREAK/MRET; anything else with this opcode is a
    // CSR access and is handled elsewhere.
    // ------------------------------------------------------------------
    assign sys_instr = (opcode_6_to_2_in == OPCODE_SYSTEM) &&
                       (funct3_in        == FUNCT3_PRIV)   &&
                       (rs1_addr_in      == 5'd0)          &&
                       (rd_addr_in       == 5'd0);

    assign is_ecall  = sys_instr && (funct12_in == FUNCT12_ECALL);
    assign is_ebreak = sys_instr && (funct12_in == FUNCT12_EBREAK);
    assign is_mret   = sys_instr && (funct12_in == FUNCT12_MRET);

    // ------------------------------------------------------------------
    // Trap qualification. A masked interrupt is simply not seen here; it
    // stays pending on its input and is picked up once it is enabled.
    // ------------------------------------------------------------------
    assign exc = misaligned_instr_in | illegal_instr_in | is_ebreak |
                 is_ecall | misaligned_load_in | misaligned_store_in;

    assign e_irq_pend = e_irq_in & meie_in;
    assign t_irq_pend = t_irq_in & mtie_in;
    assign s_irq_pend = s_irq_in & msie_in;

    assign irq = mie_in & (e_irq_pend | s_irq_pend | t_irq_pend);

    assign take_trap = (state == STATE_OPERATING) && (exc || irq);

    // Exception cause: fixed priority, highest first.
    always_comb begin
        // NOTE: a default before the if-chain keeps this purely combinational;
        // any path that left exc_cause unassigned would infer a latch.
        exc_cause = CAUSE_MISALIGNED_STORE;
        if (misaligned_instr_in)
            exc_cause = CAUSE_MISALIGNED_INSTR;
        else if (illegal_instr_in)
            exc_cause = CAUSE_ILLEGAL_INSTR;
        else if (is_ebreak)
            exc_cause = CAUSE_BREAKPOINT;
        else if (is_ecall)
            exc_cause = CAUSE_ECALL_M;
        else if (misaligned_load_in)
            exc_cause = CAUSE_MISALIGNED_LOAD;
        else if (misaligned_store_in)
            exc_cause = CAUSE_MISALIGNED_STORE;
    end

    // Interrupt cause: external over software over timer.
    always_comb begin
        irq_cause = CAUSE_TIMER_IRQ;
        if (e_irq_pend)
            irq_cause = CAUSE_EXT_IRQ;
        else if (s_irq_pend)
            irq_cause = CAUSE_SW_IRQ;
        else if (t_irq_pend)
            irq_cause = CAUSE_TIMER_IRQ;
    end

    // State register; reset forces RESET at once, independent of the clock.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n_in)
            state <= STATE_RESET;
        else
            state <= next_state;
    end

    // Next-state logic: exceptions beat interrupts, interrupts beat MRET.
    always_comb begin
        next_state = STATE_RESET;
        case (state)
            STATE_RESET:
                next_state = STATE_OPERATING;
            STATE_OPERATING: begin
                if (exc || irq)
                    next_state = STATE_TRAP_TAKEN;
                else if (is_mret)
                    next_state = STATE_TRAP_RETURN;
                else
                    next_state = STATE_OPERATING;
            end
            STATE_TRAP_TAKEN:
                next_state = STATE_OPERATING;
            STATE_TRAP_RETURN:
                next_state = STATE_OPERATING;
            default:
                next_state = STATE_RESET;
        endcase
    end

    // Cause / interrupt-flag capture on the edge that enters TRAP_TAKEN.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cause_out  <= 4'd0;
            i_or_e_out <= 1'b0;
        end else if (take_trap) begin
            cause_out  <= exc ? exc_cause : irq_cause;
            i_or_e_out <= ~exc;
        end
    end

    // Moore outputs per state; instret_inc in OPERATING is gated by the
    // instruction that is about to trap, so it does not retire.
    always_comb begin
        trap_taken_out  = 1'b0;
        pc_src_out      = BOOT_SEL;
        flush_out       = 1'b1;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        case (state)
            STATE_RESET: begin
                pc_src_out = BOOT_SEL;
                flush_out  = 1'b1;
            end
            STATE_OPERATING: begin
                pc_src_out      = NEXT_SEL;
                flush_out       = 1'b0;
                instret_inc_out = ~(exc | irq);
            end
            STATE_TRAP_TAKEN: begin
                trap_taken_out = 1'b1;
                pc_src_out     = TVEC_SEL;
                flush_out      = 1'b1;
                set_epc_out    = 1'b1;
                set_cause_out  = 1'b1;
                mie_clear_out  = 1'b1;
            end
            STATE_TRAP_RETURN: begin
                pc_src_out      = EPC_SEL;
                flush_out       = 1'b1;
                mie_set_out     = 1'b1;
                instret_inc_out = 1'b1;
            end
            default: begin
                pc_src_out = BOOT_SEL;
                flush_out  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_msrv_32_machine_control.sv
// Testbench for msrv_32_machine_control.
// Each scenario task drives a short stimulus table. For every row it pushes
// the expected post-edge output vector onto a scoreboard queue, advances one
// clock, and pops and compares it against the DUT outputs.

module tb_msrv_32_machine_control;

    // exception mask bits
    localparam int X_INSTR = 1;
    localparam int X_ILL   = 2;
    localparam int X_LD    = 4;
    localparam int X_ST    = 8;
    // system instruction selector
    localparam int SYS_NONE   = 0;
    localparam int SYS_ECALL  = 1;
    localparam int SYS_EBREAK = 2;
    localparam int SYS_MRET   = 3;
    // interrupt request bits
    localparam int I_E = 1;
    localparam int I_T = 2;
    localparam int I_S = 4;
    // enable bits
    localparam int EN_MIE  = 1;
    localparam int EN_MEIE = 2;
    localparam int EN_MTIE = 4;
    localparam int EN_MSIE = 8;

    typedef struct packed {
        logic [3:0] exc;   // {store, load, illegal, instr}
        logic [1:0] sys;
        logic [4:0] rd;
        logic [2:0] irq;   // {s, t, e}
        logic [3:0] en;    // {msie, mtie, meie, mie}
    } stim_t;

    logic        clk_in;
    logic        rst_n_in;
    logic        illegal_instr_in;
    logic        misaligned_load_in;
    logic        misaligned_store_in;
    logic        misaligned_instr_in;
    logic [4:0]  opcode_6_to_2_in;
    logic [2:0]  funct3_in;
    logic [11:0] funct12_in;
    logic [4:0]  rs1_addr_in;
    logic [4:0]  rd_addr_in;
    logic        e_irq_in;
    logic        t_irq_in;
    logic        s_irq_in;
    logic        mie_in;
    logic        meie_in;
    logic        mtie_in;
    logic        msie_in;
    logic        trap_taken_out;
    logic [1:0]  pc_src_out;
    logic        flush_out;
    logic        set_epc_out;
    logic        set_cause_out;
    logic        mie_clear_out;
    logic        mie_set_out;
    logic        instret_inc_out;
    logic [3:0]  cause_out;
    logic        i_or_e_out;

    int          errors;
    int          checks;
    logic [13:0] sb[$];
    logic [13:0] exp_v;
    logic [13:0] obs_v;

    msrv_32_machine_control dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .illegal_instr_in    (illegal_instr_in),
        .misaligned_load_in  (misaligned_load_in),
        .misaligned_store_in (misaligned_store_in),
        .misaligned_instr_in (misaligned_instr_in),
        .opcode_6_to_2_in    (opcode_6_to_2_in),
        .funct3_in           (funct3_in),
        .funct12_in          (funct12_in),
        .rs1_addr_in         (rs1_addr_in),
        .rd_addr_in          (rd_addr_in),
        .e_irq_in            (e_irq_in),
        .t_irq_in            (t_irq_in),
        .s_irq_in            (s_irq_in),
        .mie_in              (mie_in),
        .meie_in             (meie_in),
        .mtie_in             (mtie_in),
        .msie_in             (msie_in),
        .trap_taken_out      (trap_taken_out),
        .pc_src_out          (pc_src_out),
        .flush_out           (flush_out),
        .set_epc_out         (set_epc_out),
        .set_cause_out       (set_cause_out),
        .mie_clear_out       (mie_clear_out),
        .mie_set_out         (mie_set_out),
        .instret_inc_out     (instret_inc_out),
        .cause_out           (cause_out),
        .i_or_e_out          (i_or_e_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Output vector layout:
    // {trap_taken, pc_src[1:0], flush, set_epc, set_cause, mie_clear,
    //  mie_set, instret_inc, cause[3:0], i_or_e}
    function automatic logic [13:0] pack(logic tt, logic [1:0] pc, logic fl,
                                         logic epc, logic sc, logic mc,
                                         logic ms, logic ir, logic [3:0] c,
                                         logic ie);
        return {tt, pc, fl, epc, sc, mc, ms, ir, c, ie};
    endfunction

    function automatic logic [13:0] e_reset();
        return pack(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endfunction

    function automatic logic [13:0] e_oper(logic ir, logic [3:0] c, logic ie);
        return pack(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ir, c, ie);
    endfunction

    function automatic logic [13:0] e_trap(logic [3:0] c, logic ie);
        return pack(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c, ie);
    endfunction

    function automatic logic [13:0] e_ret(logic [3:0] c, logic ie);
        return pack(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c, ie);
    endfunction

    function automatic logic [13:0] observe();
        return {trap_taken_out, pc_src_out, flush_out, set_epc_out,
                set_cause_out, mie_clear_out, mie_set_out, instret_inc_out,
                cause_out, i_or_e_out};
    endfunction

    function automatic stim_t st(int exc, int sys, int rd, int irq, int en);
        stim_t s;
        s.exc = exc[3:0];
        s.sys = sys[1:0];
        s.rd  = rd[4:0];
        s.irq = irq[2:0];
        s.en  = en[3:0];
        return s;
    endfunction

    task automatic apply(input stim_t s);
        misaligned_instr_in = s.exc[0];
        illegal_instr_in    = s.exc[1];
        misaligned_load_in  = s.exc[2];
        misaligned_store_in = s.exc[3];
        if (s.sys == 2'(SYS_NONE)) begin
            opcode_6_to_2_in = 5'b01100;
            funct12_in       = 12'h000;
        end else begin
            opcode_6_to_2_in = 5'b11100;
            case (s.sys)
                2'(SYS_ECALL):  funct12_in = 12'h000;
                2'(SYS_EBREAK): funct12_in = 12'h001;
                default:        funct12_in = 12'h302;
            endcase
        end
        funct3_in   = 3'b000;
        rs1_addr_in = 5'd0;
        rd_addr_in  = s.rd;
        e_irq_in    = s.irq[0];
        t_irq_in    = s.irq[1];
        s_irq_in    = s.irq[2];
        mie_in      = s.en[0];
        meie_in     = s.en[1];
        mtie_in     = s.en[2];
        msie_in     = s.en[3];
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        apply(st(0, SYS_NONE, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rst_n_in = 1'b1;
            sb.push_back(i == 3 ? e_oper(1'b1, 4'd0, 1'b0) : e_reset());
            tick();
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL reset step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    task automatic test_illegal();
        stim_t s[2];
        logic [13:0] e[2];
        s[0] = st(X_ILL, SYS_NONE, 0, 0, 0); e[0] = e_trap(4'd2, 1'b0);
        s[1] = st(0, SYS_NONE, 0, 0, 0);     e[1] = e_oper(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            tick();
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL illegal step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    task automatic test_exc_beats_irq();
        stim_t s[6];
        logic [13:0] e[6];
        s[0] = st(X_LD, SYS_NONE, 0, I_E, EN_MIE | EN_MEIE); e[0] = e_trap(4'd4, 1'b0);
        s[1] = st(0, SYS_MRET, 0, I_E, EN_MEIE);             e[1] = e_oper(1'b1, 4'd4, 1'b0);
        s[2] = st(0, SYS_MRET, 0, I_E, EN_MEIE);             e[2] = e_ret(4'd4, 1'b0);
        s[3] = st(0, SYS_NONE, 0, I_E, EN_MIE | EN_MEIE);    e[3] = e_oper(1'b0, 4'd4, 1'b0);
        s[4] = st(0, SYS_NONE, 0, I_E, EN_MIE | EN_MEIE);    e[4] = e_trap(4'd11, 1'b1);
        s[5] = st(0, SYS_NONE, 0, 0, 0);                     e[5] = e_oper(1'b1, 4'd11, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            tick();
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL exc_beats_irq step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    task automatic test_irq_masked();
        stim_t s[4];
        logic [13:0] e[4];
        s[0] = st(0, SYS_NONE, 0, I_T, EN_MTIE);          e[0] = e_oper(1'b1, 4'd11, 1'b1);
        s[1] = st(0, SYS_NONE, 0, I_T, EN_MTIE);          e[1] = e_oper(1'b1, 4'd11, 1'b1);
        s[2] = st(0, SYS_NONE, 0, I_T, EN_MTIE | EN_MIE); e[2] = e_trap(4'd7, 1'b1);
        s[3] = st(0, SYS_NONE, 0, 0, 0);                  e[3] = e_oper(1'b1, 4'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            tick();
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL irq_masked step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    task automatic test_irq_priority();
        stim_t s[6];
        logic [13:0] e[6];
        s[0] = st(0, SYS_NONE, 0, I_S | I_T, EN_MIE | EN_MSIE | EN_MTIE);  e[0] = e_trap(4'd3, 1'b1);
        s[1] = st(0, SYS_NONE, 0, 0, 0);                                   e[1] = e_oper(1'b1, 4'd3, 1'b1);
        s[2] = st(0, SYS_NONE, 0, I_E | I_S | I_T, 15);                    e[2] = e_trap(4'd11, 1'b1);
        s[3] = st(0, SYS_NONE, 0, 0, 0);                                   e[3] = e_oper(1'b1, 4'd11, 1'b1);
        s[4] = st(0, SYS_NONE, 0, I_E | I_T, EN_MIE | EN_MTIE);            e[4] = e_trap(4'd7, 1'b1);
        s[5] = st(0, SYS_NONE, 0, 0, 0);                                   e[5] = e_oper(1'b1, 4'd7, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            tick();
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL irq_priority step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    task automatic test_system();
        stim_t s[6];
        logic [13:0] e[6];
        s[0] = st(0, SYS_ECALL, 0, 0, 0);  e[0] = e_trap(4'd11, 1'b0);
        s[1] = st(0, SYS_NONE, 0, 0, 0);   e[1] = e_oper(1'b1, 4'd11, 1'b0);
        s[2] = st(0, SYS_EBREAK, 0, 0, 0); e[2] = e_trap(4'd3, 1'b0);
        s[3] = st(0, SYS_NONE, 0, 0, 0);   e[3] = e_oper(1'b1, 4'd3, 1'b0);
        s[4] = st(0, SYS_ECALL, 5, 0, 0);  e[4] = e_oper(1'b1, 4'd3, 1'b0);
        s[5] = st(0, SYS_MRET, 5, 0, 0);   e[5] = e_oper(1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            tick();
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL system step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    task automatic test_exc_priority();
        stim_t s[10];
        logic [13:0] e[10];
        s[0] = st(X_INSTR | X_ILL | X_LD | X_ST, SYS_EBREAK, 0, 0, 0); e[0] = e_trap(4'd0, 1'b0);
        s[1] = st(0, SYS_NONE, 0, 0, 0);                               e[1] = e_oper(1'b1, 4'd0, 1'b0);
        s[2] = st(X_ILL | X_LD, SYS_ECALL, 0, 0, 0);                   e[2] = e_trap(4'd2, 1'b0);
        s[3] = st(0, SYS_NONE, 0, 0, 0);                               e[3] = e_oper(1'b1, 4'd2, 1'b0);
        s[4] = st(X_LD | X_ST, SYS_ECALL, 0, 0, 0);                    e[4] = e_trap(4'd11, 1'b0);
        s[5] = st(0, SYS_NONE, 0, 0, 0);                               e[5] = e_oper(1'b1, 4'd11, 1'b0);
        s[6] = st(X_LD | X_ST, SYS_NONE, 0, 0, 0);                     e[6] = e_trap(4'd4, 1'b0);
        s[7] = st(0, SYS_NONE, 0, 0, 0);                               e[7] = e_oper(1'b1, 4'd4, 1'b0);
        s[8] = st(X_ST, SYS_NONE, 0, I_E, EN_MIE | EN_MEIE);           e[8] = e_trap(4'd6, 1'b0);
        s[9] = st(0, SYS_NONE, 0, 0, 0);                               e[9] = e_oper(1'b1, 4'd6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            tick();
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL exc_priority step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    // Held exception: TRAP_TAKEN always exits after one cycle, then the
    // still-asserted flag traps again from OPERATING.
    task automatic test_back_to_back();
        stim_t s[5];
        logic [13:0] e[5];
        s[0] = st(X_ILL, SYS_NONE, 0, 0, 0); e[0] = e_trap(4'd2, 1'b0);
        s[1] = st(X_ILL, SYS_NONE, 0, 0, 0); e[1] = e_oper(1'b0, 4'd2, 1'b0);
        s[2] = st(X_ILL, SYS_NONE, 0, 0, 0); e[2] = e_trap(4'd2, 1'b0);
        s[3] = st(X_ILL, SYS_NONE, 0, 0, 0); e[3] = e_oper(1'b0, 4'd2, 1'b0);
        s[4] = st(0, SYS_NONE, 0, 0, 0);     e[4] = e_oper(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            sb.push_back(e[i]);
            tick();
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL back_to_back step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    // Reset pulled mid-trap must drop all strobes without waiting for a clock.
    task automatic test_reset_in_trap();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    apply(st(X_ILL, SYS_NONE, 0, 0, 0));
                    sb.push_back(e_trap(4'd2, 1'b0));
                    tick();
                end
                1: begin
                    apply(st(0, SYS_NONE, 0, 0, 0));
                    rst_n_in = 1'b0;
                    sb.push_back(e_reset());
                    #1;
                end
                2: begin
                    sb.push_back(e_reset());
                    tick();
                end
                default: begin
                    rst_n_in = 1'b1;
                    sb.push_back(e_oper(1'b1, 4'd0, 1'b0));
                    tick();
                end
            endcase
            exp_v = sb.pop_front();
            obs_v = observe();
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL reset_in_trap step %0d: got %h expected %h", i, obs_v, exp_v);
                errors++;
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n_in = 1'b0;
        apply(st(0, SYS_NONE, 0, 0, 0));
        #2;
        test_reset();
        test_illegal();
        test_exc_beats_irq();
        test_irq_masked();
        test_irq_priority();
        test_system();
        test_exc_priority();
        test_back_to_back();
        test_reset_in_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
